// File: rtl/alu_issue_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_pkg
//   Shared constants and types for the ALU issue unit: ALU select codes,
//   opcode/funct encodings understood by the decoder, and the FSM state type.
// -----------------------------------------------------------------------------
package alu_issue_pkg;

   // ALU select codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_EQ  = 3'b110;
   localparam logic [2:0] ALU_LT  = 3'b111;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   // R-type funct codes
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// -----------------------------------------------------------------------------
// alu_issue_decode
//   Combinational decoder: maps opcode/funct (plus imm and rt value) to the ALU
//   select code and the second ALU operand, and flags unlisted encodings.
//   Ports:
//     opcode_i, funct_i : instruction opcode / funct field
//     imm_i             : 16-bit immediate
//     rt_i              : rt register value
//     sel_o             : 3-bit ALU select
//     op2_o             : ALU operand 2 (rt, sign- or zero-extended imm)
//     illegal_o         : 1 when the opcode/funct pair is not recognised
// -----------------------------------------------------------------------------
module alu_issue_decode
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   input  logic [15:0]       imm_i,
   input  logic [DATA_W-1:0] rt_i,
   output logic [2:0]        sel_o,
   output logic [DATA_W-1:0] op2_o,
   output logic              illegal_o
);

   localparam int EXT_W = DATA_W - 16;

   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_zext;

   assign imm_sext = {{EXT_W{imm_i[15]}}, imm_i};
   assign imm_zext = {{EXT_W{1'b0}}, imm_i};

   always_comb begin
      // NOTE: every output gets a default before the case so no path can leave
      // it unassigned; otherwise synthesis infers a latch.
      sel_o     = ALU_ADD;
      op2_o     = rt_i;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OP_RTYPE: begin
            unique case (funct_i)
               FN_ADD, FN_ADDU: sel_o = ALU_ADD;
               FN_SUB, FN_SUBU: sel_o = ALU_SUB;
               FN_AND:          sel_o = ALU_AND;
               FN_OR:           sel_o = ALU_OR;
               FN_XOR:          sel_o = ALU_XOR;
               FN_NOR:          sel_o = ALU_NOR;
               FN_SLT, FN_SLTU: sel_o = ALU_LT;
               default:         illegal_o = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin sel_o = ALU_ADD; op2_o = imm_sext; end
         OP_SLTI, OP_SLTIU: begin sel_o = ALU_LT;  op2_o = imm_sext; end
         OP_ANDI:           begin sel_o = ALU_AND; op2_o = imm_zext; end
         OP_ORI:            begin sel_o = ALU_OR;  op2_o = imm_zext; end
         OP_XORI:           begin sel_o = ALU_XOR; op2_o = imm_zext; end
         OP_BEQ, OP_BNE:    sel_o = ALU_SUB;
         default:           illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//   Issue-side partner of the datapath ALU. Accepts a decoded op over an
//   in_valid/in_ready handshake, drives registered operands/select to the ALU,
//   captures the ALU result one cycle later and offers it downstream over an
//   out_valid/out_ready handshake. FSM: IDLE -> EXEC -> DONE.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     in_valid/in_ready            : upstream handshake
//     in_opcode/in_funct/in_imm    : instruction fields
//     in_rs_val/in_rt_val/in_tag   : operands and destination tag
//     alu_inp1/alu_inp2/alu_sel    : registered ALU inputs
//     alu_out/alu_zero             : combinational ALU result / zero flag
//     out_valid/out_ready          : downstream handshake
//     out_result/out_zero/out_tag  : captured result, zero flag and tag
//     out_illegal                  : only with ALU_ISSUE_ILLEGAL_TRAP_EN
//   Build option ALU_ISSUE_ILLEGAL_TRAP_EN: unlisted ops complete with
//   out_illegal=1 and a zero result instead of executing as add.
// -----------------------------------------------------------------------------
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   input  logic [15:0]       in_imm,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [DATA_W-1:0] alu_inp1,
   output logic [DATA_W-1:0] alu_inp2,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [TAG_W-1:0]  out_tag
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   ,
   output logic              out_illegal
`endif
);

   state_e            state_q;
   logic [DATA_W-1:0] alu_inp1_q;
   logic [DATA_W-1:0] alu_inp2_q;
   logic [2:0]        alu_sel_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] out_result_q;
   logic              out_zero_q;
   logic              out_valid_q;
   logic [TAG_W-1:0]  out_tag_q;

   logic [2:0]        sel_d;
   logic [DATA_W-1:0] op2_d;
   logic              illegal_d;
   logic              accept;

   alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
      .opcode_i  (in_opcode),
      .funct_i   (in_funct),
      .imm_i     (in_imm),
      .rt_i      (in_rt_val),
      .sel_o     (sel_d),
      .op2_o     (op2_d),
      .illegal_o (illegal_d)
   );

   // A finished result frees the unit in the same cycle it is taken downstream.
   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic illegal_q;
   logic out_illegal_q;
   assign out_illegal = out_illegal_q;
`else
   // Unlisted ops simply execute as add; the flag has no consumer here.
   logic unused_illegal;
   assign unused_illegal = illegal_d;
`endif

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= IDLE;
         alu_inp1_q   <= '0;
         alu_inp2_q   <= '0;
         alu_sel_q    <= ALU_ADD;
         tag_q        <= '0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_tag_q    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
         illegal_q     <= 1'b0;
         out_illegal_q <= 1'b0;
`endif
      end else begin
         // ALU inputs only move on an accept edge and are held otherwise.
         if (accept) begin
            alu_inp1_q <= in_rs_val;
            alu_inp2_q <= op2_d;
            alu_sel_q  <= sel_d;
            tag_q      <= in_tag;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
         end
         unique case (state_q)
            IDLE: begin
               if (in_valid) state_q <= EXEC;
            end
            EXEC: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
               if (illegal_q) begin
                  out_result_q <= '0;
                  out_zero_q   <= 1'b0;
               end else begin
                  out_result_q <= alu_out;
                  out_zero_q   <= alu_zero;
               end
               out_illegal_q <= illegal_q;
`else
               out_result_q <= alu_out;
               out_zero_q   <= alu_zero;
`endif
               out_tag_q   <= tag_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= in_valid ? EXEC : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_inp1   = alu_inp1_q;
   assign alu_inp2   = alu_inp2_q;
   assign alu_sel    = alu_sel_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
//   Self-checking bench for alu_issue_unit. Provides a behavioural ALU on the
//   alu_* ports, applies a table of directed ops, a block of random ops checked
//   against an instruction-level reference model, and hand-written sequences
//   for backpressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        in_opcode;
   logic [5:0]        in_funct;
   logic [DATA_W-1:0] in_rs_val;
   logic [DATA_W-1:0] in_rt_val;
   logic [15:0]       in_imm;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] alu_inp1;
   logic [DATA_W-1:0] alu_inp2;
   logic [2:0]        alu_sel;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zero;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_zero;
   logic [TAG_W-1:0]  out_tag;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic              out_illegal;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_issue_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_funct   (in_funct),
      .in_rs_val  (in_rs_val),
      .in_rt_val  (in_rt_val),
      .in_imm     (in_imm),
      .in_tag     (in_tag),
      .alu_inp1   (alu_inp1),
      .alu_inp2   (alu_inp2),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_tag    (out_tag)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      ,
      .out_illegal(out_illegal)
`endif
   );

   // Behavioural datapath ALU
   function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         3'd6:    return (a == b) ? 32'd1 : 32'd0;
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_out  = alu_fn(alu_sel, alu_inp1, alu_inp2);
      alu_zero = (alu_out == 32'd0);
   end

   typedef struct {
      logic [5:0]  opc;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [4:0]  tag;
      logic [2:0]  sel;
      logic [31:0] op2;
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] funct,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] imm, input logic [4:0] tag,
                               input logic [2:0] sel, input logic [31:0] op2,
                               input logic [31:0] res, input logic zero, input logic ill);
      vec_t v;
      v.opc = opc; v.funct = funct; v.rs = rs; v.rt = rt; v.imm = imm; v.tag = tag;
      v.sel = sel; v.op2 = op2; v.res = res; v.zero = zero; v.ill = ill;
      return v;
   endfunction

   // Instruction-level reference: what the op means, then what it produces.
   function automatic vec_t ref_op(input logic [5:0] opc, input logic [5:0] funct,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic [4:0] tag);
      vec_t v;
      logic [31:0] sx;
      logic [31:0] zx;
      sx = {{16{imm[15]}}, imm};
      zx = {16'h0000, imm};
      v = mk(opc, funct, rs, rt, imm, tag, 3'd0, rt, 32'd0, 1'b0, 1'b0);
      if (opc == 6'h00) begin
         case (funct)
            6'h20, 6'h21: v.sel = 3'd0;
            6'h22, 6'h23: v.sel = 3'd1;
            6'h24:        v.sel = 3'd2;
            6'h25:        v.sel = 3'd3;
            6'h26:        v.sel = 3'd5;
            6'h27:        v.sel = 3'd4;
            6'h2A, 6'h2B: v.sel = 3'd7;
            default:      v.ill = 1'b1;
         endcase
      end else begin
         case (opc)
            6'h08, 6'h09: begin v.sel = 3'd0; v.op2 = sx; end
            6'h0A, 6'h0B: begin v.sel = 3'd7; v.op2 = sx; end
            6'h0C:        begin v.sel = 3'd2; v.op2 = zx; end
            6'h0D:        begin v.sel = 3'd3; v.op2 = zx; end
            6'h0E:        begin v.sel = 3'd5; v.op2 = zx; end
            6'h04, 6'h05: v.sel = 3'd1;
            default:      v.ill = 1'b1;
         endcase
      end
      v.res  = alu_fn(v.sel, rs, v.op2);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      if (v.ill) v.res = 32'd0;
`endif
      v.zero = (v.res == 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      if (v.ill) v.zero = 1'b0;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      in_opcode = v.opc;
      in_funct  = v.funct;
      in_rs_val = v.rs;
      in_rt_val = v.rt;
      in_imm    = v.imm;
      in_tag    = v.tag;
   endtask

   // Full single-op transaction from IDLE; checks ALU drive, latency, result
   // fields and the return to IDLE.
   task automatic run_op(input vec_t v, input string nm);
      @(negedge clk);
      check($sformatf("%s in_ready idle", nm), {31'd0, in_ready}, 32'd1);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("%s alu_sel", nm), {29'd0, alu_sel}, {29'd0, v.sel});
      check($sformatf("%s alu_inp1", nm), alu_inp1, v.rs);
      check($sformatf("%s alu_inp2", nm), alu_inp2, v.op2);
      check($sformatf("%s out_valid exec", nm), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("%s out_valid done", nm), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s out_result", nm), out_result, v.res);
      check($sformatf("%s out_zero", nm), {31'd0, out_zero}, {31'd0, v.zero});
      check($sformatf("%s out_tag", nm), {27'd0, out_tag}, {27'd0, v.tag});
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      check($sformatf("%s out_illegal", nm), {31'd0, out_illegal}, {31'd0, v.ill});
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("%s out_valid drained", nm), {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      vec_t v;
      vec_t v2;
      logic [5:0] opc_pool[12];
      logic [5:0] fn_pool[12];

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = '0; in_funct = '0; in_rs_val = '0; in_rt_val = '0; in_imm = '0; in_tag = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset alu_sel", {29'd0, alu_sel}, 32'd0);
      check("reset alu_inp1", alu_inp1, 32'd0);
      check("reset alu_inp2", alu_inp2, 32'd0);
      check("reset out_result", out_result, 32'd0);
      check("reset out_zero", {31'd0, out_zero}, 32'd0);
      check("reset out_tag", {27'd0, out_tag}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      check("reset out_illegal", {31'd0, out_illegal}, 32'd0);
`endif

      // Directed table: opc, funct, rs, rt, imm, tag, sel, op2, res, zero, ill
      vecs.push_back(mk(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 5'd1, 3'd0, 32'd7, 32'd12, 1'b0, 1'b0));
      vecs.push_back(mk(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0000, 5'd2, 3'd1, 32'h1234, 32'd0, 1'b1, 1'b0));
      vecs.push_back(mk(6'h08, 6'h00, 32'd1, 32'd99, 16'hFFFF, 5'd3, 3'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0));
      vecs.push_back(mk(6'h0C, 6'h00, 32'd1, 32'd99, 16'hFFFF, 5'd4, 3'd2, 32'h0000FFFF, 32'd1, 1'b0, 1'b0));
      vecs.push_back(mk(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0000, 5'd5, 3'd7, 32'd1, 32'd1, 1'b0, 1'b0));
      vecs.push_back(mk(6'h00, 6'h27, 32'd0, 32'd0, 16'h0000, 5'd6, 3'd4, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(6'h0E, 6'h00, 32'd0, 32'd5, 16'h8000, 5'd7, 3'd5, 32'h00008000, 32'h00008000, 1'b0, 1'b0));
      vecs.push_back(mk(6'h0A, 6'h00, 32'd0, 32'd5, 16'h8000, 5'd8, 3'd7, 32'hFFFF8000, 32'd0, 1'b1, 1'b0));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      vecs.push_back(mk(6'h3F, 6'h00, 32'd10, 32'd20, 16'h0000, 5'd9, 3'd0, 32'd20, 32'd0, 1'b0, 1'b1));
      vecs.push_back(mk(6'h00, 6'h3F, 32'd3, 32'hFFFFFFFD, 16'h0000, 5'd10, 3'd0, 32'hFFFFFFFD, 32'd0, 1'b0, 1'b1));
`else
      vecs.push_back(mk(6'h3F, 6'h00, 32'd10, 32'd20, 16'h0000, 5'd9, 3'd0, 32'd20, 32'd30, 1'b0, 1'b1));
      vecs.push_back(mk(6'h00, 6'h3F, 32'd3, 32'hFFFFFFFD, 16'h0000, 5'd10, 3'd0, 32'hFFFFFFFD, 32'd0, 1'b1, 1'b1));
`endif
      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Random ops against the reference model
      opc_pool = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h3F};
      fn_pool  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h3F};
      for (int i = 0; i < 40; i++) begin
         v = ref_op(opc_pool[$urandom_range(11, 0)], fn_pool[$urandom_range(11, 0)],
                    $urandom(), ($urandom_range(3, 0) == 0) ? 32'h1234 : $urandom(),
                    16'($urandom()), 5'($urandom()));
         if (i % 8 == 0) v = ref_op(v.opc, v.funct, 32'h1234, 32'h1234, v.imm, v.tag);
         run_op(v, $sformatf("rand%0d", i));
      end

      // Backpressure: hold out_ready low, then accept a new op in the same
      // cycle the old result leaves.
      v  = ref_op(6'h00, 6'h20, 32'd100, 32'd23, 16'h0000, 5'd9);
      v2 = ref_op(6'h00, 6'h22, 32'd50, 32'd8, 16'h0000, 5'd3);
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp%0d out_result", i), out_result, 32'd123);
         check($sformatf("bp%0d out_tag", i), {27'd0, out_tag}, 32'd9);
         check($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
         check($sformatf("bp%0d alu_inp2", i), alu_inp2, 32'd23);
         @(negedge clk);
      end
      drive(v2);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("bp same-cycle in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp2 out_valid exec", {31'd0, out_valid}, 32'd0);
      check("bp2 alu_sel", {29'd0, alu_sel}, 32'd1);
      check("bp2 alu_inp2", alu_inp2, 32'd8);
      @(negedge clk);
      check("bp2 out_valid done", {31'd0, out_valid}, 32'd1);
      check("bp2 out_result", out_result, 32'd42);
      check("bp2 out_tag", {27'd0, out_tag}, 32'd3);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp2 drained in_ready", {31'd0, in_ready}, 32'd1);

      // Reset while in EXEC: op discarded, no out_valid afterwards.
      v = ref_op(6'h0D, 6'h00, 32'hF0F0F0F0, 32'd0, 16'h1234, 5'd17);
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("rst pre alu_sel", {29'd0, alu_sel}, 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst alu_sel", {29'd0, alu_sel}, 32'd0);
      check("rst alu_inp1", alu_inp1, 32'd0);
      check("rst alu_inp2", alu_inp2, 32'd0);
      check("rst out_result", out_result, 32'd0);
      check("rst out_tag", {27'd0, out_tag}, 32'd0);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("rst no late out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("rst still idle out_valid", {31'd0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
